// File: rtl/ndigit_bcd_updown_counter.sv
// ndigit_bcd_updown_counter
//   N-digit packed-BCD up/down counter with synchronous load, a run-time
//   programmable terminal value (limit) and a wrap-or-saturate terminal mode.
//   count and done are both registered; there is no combinational in->out path.
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset (count=0, done=0)
//   enable    step request
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous load strobe (priority over enable)
//   load_val  packed BCD load value, digit i = bits [4i+3:4i]
//   limit     packed BCD terminal value
//   count     packed BCD count
//   done      one-cycle pulse after a step taken at terminal
module ndigit_bcd_updown_counter #(
  parameter int unsigned N    = 3,
  parameter bit          WRAP = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           up,
  input  logic           load,
  input  logic [4*N-1:0] load_val,
  input  logic [4*N-1:0] limit,
  output logic [4*N-1:0] count,
  output logic           done
);

  localparam int unsigned W = 4 * N;

  logic [W-1:0] count_q, count_d;
  logic         done_q,  done_d;
  logic [W-1:0] lim_s, ld_s;

  // Clamp every digit above 9 to 9 so all downstream values are valid BCD.
  function automatic logic [W-1:0] bcd_sanitise(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    logic [3:0]   d;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          d     = 4'd0;
          carry = 1'b1;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   d;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d      = 4'd9;
          borrow = 1'b1;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  always_comb begin
    lim_s = bcd_sanitise(limit);
    ld_s  = bcd_sanitise(load_val);
  end

  // Packed BCD orders the same as unsigned binary, so plain compares are used.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = (ld_s < lim_s) ? ld_s : lim_s;
    end else if (enable) begin
      if (up) begin
        if (count_q < lim_s) begin
          count_d = bcd_inc(count_q);
        end else begin
          // Also reached when limit was lowered below count at run time.
          count_d = WRAP ? '0 : count_q;
          done_d  = 1'b1;
        end
      end else begin
        if (count_q > lim_s) begin
          count_d = lim_s;
        end else if (count_q != '0) begin
          count_d = bcd_dec(count_q);
        end else begin
          count_d = WRAP ? lim_s : count_q;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;

endmodule
